// File: rtl/pio_seq_pkg.sv
// rtl/pio_seq_pkg.sv - shared types and constants for the PIO LED sequencer
// Purpose: FSM state encoding, pattern mode encodings, cfg register word
//          offsets and shift-direction encoding.
// Ports:   none (package)
package pio_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_WAIT,
    ST_STEP
  } state_e;

  typedef enum logic [1:0] {
    MODE_CHASE  = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_MANUAL = 2'd3
  } mode_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_MANUAL = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // Left (towards the MSB) is the reset direction and reads back as 0.
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/pio_seq_pattern_gen.sv
// rtl/pio_seq_pattern_gen.sv - combinational seed / next-pattern generator
// Purpose: computes the pattern loaded when the sequencer starts and the
//          pattern/direction that follows the current one for each mode.
// Ports:
//   pattern       in   current LED pattern
//   dir           in   current bounce direction
//   mode          in   pattern mode (chase, bounce, blink, manual)
//   manual        in   MANUAL register value
//   seed_pattern  out  starting pattern for the mode
//   next_pattern  out  pattern after one step
//   next_dir      out  bounce direction after one step
module pio_seq_pattern_gen
  import pio_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 10
) (
  input  logic [DATA_WIDTH-1:0] pattern,
  input  logic                  dir,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] manual,
  output logic [DATA_WIDTH-1:0] seed_pattern,
  output logic [DATA_WIDTH-1:0] next_pattern,
  output logic                  next_dir
);

  always_comb begin
    seed_pattern = DATA_WIDTH'(1);
    case (mode_e'(mode))
      MODE_BLINK:  seed_pattern = '1;
      MODE_MANUAL: seed_pattern = manual;
      default:     seed_pattern = DATA_WIDTH'(1);
    endcase
  end

  always_comb begin
    next_pattern = pattern;
    next_dir     = dir;
    case (mode_e'(mode))
      // Rotate left; the shift pair also works for a 1-bit bank.
      MODE_CHASE: next_pattern = (pattern << 1) | (pattern >> (DATA_WIDTH - 1));
      MODE_BOUNCE: begin
        // A bit already parked at an end moves away from it, so switching in
        // from chase with the MSB lit turns around instead of dropping off.
        if ((dir == DIR_LEFT && !pattern[DATA_WIDTH-1]) || (dir == DIR_RIGHT && pattern[0])) begin
          next_pattern = pattern << 1;
          next_dir     = next_pattern[DATA_WIDTH-1] ? DIR_RIGHT : DIR_LEFT;
        end else begin
          next_pattern = pattern >> 1;
          next_dir     = next_pattern[0] ? DIR_LEFT : DIR_RIGHT;
        end
      end
      MODE_BLINK:  next_pattern = ~pattern;
      MODE_MANUAL: next_pattern = manual;
      default:     next_pattern = pattern;
    endcase
  end

endmodule

// File: rtl/pio_led_sequencer.sv
// rtl/pio_led_sequencer.sv - autonomous LED pattern sequencer for the output PIO
// Purpose: CPU-configured (Avalon-MM slave) sequencer that periodically issues
//          single-beat Avalon-MM writes of a pattern to PIO offset 0.
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   avs_address/chipselect/
//   avs_write_n/writedata      cfg slave: 0 CTRL, 1 PERIOD, 2 MANUAL, 3 STATUS
//   avs_readdata               cfg read data (combinational, zero-extended)
//   avm_address/chipselect/
//   avm_write_n/writedata      master write port towards PIO s1
//   avm_waitrequest            interconnect stall
module pio_led_sequencer #(
  parameter int                     DATA_WIDTH   = 10,
  parameter int                     PERIOD_W     = 32,
  parameter logic [PERIOD_W-1:0]    RESET_PERIOD = PERIOD_W'(50000000)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  avs_address,
  input  logic        avs_chipselect,
  input  logic        avs_write_n,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest
);
  import pio_seq_pkg::*;

  state_e                state_q, state_d;
  logic                  en_q, en_d;
  logic [1:0]            mode_q, mode_d;
  logic [PERIOD_W-1:0]   period_q, period_d;
  logic [PERIOD_W-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] manual_q, manual_d;
  logic [DATA_WIDTH-1:0] pattern_q, pattern_d;
  logic                  dir_q, dir_d;

  logic                  cfg_wr;
  logic [DATA_WIDTH-1:0] seed_pattern, next_pattern;
  logic                  next_dir;
  logic [PERIOD_W-1:0]   cnt_load;

  pio_seq_pattern_gen #(.DATA_WIDTH(DATA_WIDTH)) u_pattern_gen (
    .pattern      (pattern_q),
    .dir          (dir_q),
    .mode         (mode_q),
    .manual       (manual_q),
    .seed_pattern (seed_pattern),
    .next_pattern (next_pattern),
    .next_dir     (next_dir)
  );

  assign cfg_wr = avs_chipselect & ~avs_write_n;

  always_comb begin
    en_d     = en_q;
    mode_d   = mode_q;
    period_d = period_q;
    manual_d = manual_q;
    if (cfg_wr) begin
      case (avs_address)
        REG_CTRL: begin
          en_d   = avs_writedata[0];
          mode_d = avs_writedata[2:1];
        end
        REG_PERIOD: period_d = avs_writedata[PERIOD_W-1:0];
        REG_MANUAL: manual_d = avs_writedata[DATA_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // PERIOD=0 is treated as 1 so the WAIT phase is never skipped.
  assign cnt_load = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);

  // Transitions look at en_d so a CTRL write acts in the very next cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pattern_d = pattern_q;
    dir_d     = dir_q;
    case (state_q)
      ST_IDLE: if (en_d) state_d = ST_LOAD;
      ST_LOAD: begin
        if (!en_d) begin
          state_d = ST_IDLE;
        end else begin
          pattern_d = seed_pattern;
          dir_d     = DIR_LEFT;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // A started beat always completes, even if EN drops while stalled.
        if (!avm_waitrequest) begin
          cnt_d   = cnt_load;
          state_d = en_d ? ST_WAIT : ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!en_d) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_STEP;
        end else begin
          cnt_d = cnt_q - PERIOD_W'(1);
        end
      end
      ST_STEP: begin
        if (!en_d) begin
          state_d = ST_IDLE;
        end else begin
          pattern_d = next_pattern;
          dir_d     = next_dir;
          state_d   = ST_WRITE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      en_q      <= 1'b0;
      mode_q    <= MODE_CHASE;
      period_q  <= RESET_PERIOD;
      manual_q  <= '0;
      cnt_q     <= '0;
      pattern_q <= '0;
      dir_q     <= DIR_LEFT;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      period_q  <= period_d;
      manual_q  <= manual_d;
      cnt_q     <= cnt_d;
      pattern_q <= pattern_d;
      dir_q     <= dir_d;
    end
  end

  always_comb begin
    avs_readdata = '0;
    case (avs_address)
      REG_CTRL:   avs_readdata[2:0] = {mode_q, en_q};
      REG_PERIOD: avs_readdata = 32'(period_q);
      REG_MANUAL: avs_readdata[DATA_WIDTH-1:0] = manual_q;
      REG_STATUS: begin
        avs_readdata[DATA_WIDTH-1:0] = pattern_q;
        avs_readdata[31]             = (state_q != ST_IDLE);
        avs_readdata[30]             = dir_q;
      end
      default: avs_readdata = '0;
    endcase
  end

  assign avm_address    = 2'b00;
  assign avm_chipselect = (state_q == ST_WRITE);
  assign avm_write_n    = ~(state_q == ST_WRITE);
  assign avm_writedata  = 32'(pattern_q);

endmodule

// File: tb/tb_pio_led_sequencer.sv
// tb/tb_pio_led_sequencer.sv - self-checking bench for pio_led_sequencer
module tb_pio_led_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_chipselect = 1'b0;
  logic        avs_write_n = 1'b1;
  logic [31:0] avs_writedata = 32'd0;
  logic [31:0] avs_readdata;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] beat_dat[$];
  int          beat_cyc[$];
  logic [31:0] strb_dat[$];
  int          strb_idx[$];
  int          stall_idx = -1;
  int          stall_left = 0;

  pio_led_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .avs_address     (avs_address),
    .avs_chipselect  (avs_chipselect),
    .avs_write_n     (avs_write_n),
    .avs_writedata   (avs_writedata),
    .avs_readdata    (avs_readdata),
    .avm_address     (avm_address),
    .avm_chipselect  (avm_chipselect),
    .avm_write_n     (avm_write_n),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // PIO-side responder: stalls a chosen beat and records every strobe cycle
  // and every accepted beat.
  initial begin
    avm_waitrequest = 1'b0;
    forever begin
      @(negedge clk);
      if (avm_chipselect && !avm_write_n) begin
        if (beat_dat.size() == stall_idx && stall_left > 0) begin
          avm_waitrequest = 1'b1;
          stall_left--;
        end else begin
          avm_waitrequest = 1'b0;
        end
        strb_dat.push_back(avm_writedata);
        strb_idx.push_back(beat_dat.size());
        if (!avm_waitrequest) begin
          beat_dat.push_back(avm_writedata);
          beat_cyc.push_back(cyc);
        end
      end else begin
        avm_waitrequest = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
    avs_address    = a;
    avs_writedata  = d;
    avs_chipselect = 1'b1;
    avs_write_n    = 1'b0;
    tick();
    avs_chipselect = 1'b0;
    avs_write_n    = 1'b1;
  endtask

  task automatic cfg_rd(input logic [1:0] a, output logic [31:0] d);
    avs_address    = a;
    avs_chipselect = 1'b1;
    avs_write_n    = 1'b1;
    @(negedge clk);
    d = avs_readdata;
    tick();
    avs_chipselect = 1'b0;
  endtask

  task automatic clear_log();
    beat_dat.delete();
    beat_cyc.delete();
    strb_dat.delete();
    strb_idx.delete();
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int t = 0;
    while (beat_dat.size() < n && t < budget) begin
      tick();
      t++;
    end
    checks++;
    if (beat_dat.size() < n) begin
      errors++;
      $display("FAIL %s beat count: got %0d required %0d", tag, beat_dat.size(), n);
    end
  endtask

  task automatic stop_seq();
    stall_left = 0;
    stall_idx  = -1;
    cfg_wr(2'd0, 32'd0);
    repeat (10) tick();
    clear_log();
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    cfg_rd(2'd0, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset CTRL: got 0x%08h required 0x00000000", rd); end
    cfg_rd(2'd1, rd);
    checks++; if (rd !== 32'd50000000) begin errors++; $display("FAIL reset PERIOD: got %0d required 50000000", rd); end
    cfg_rd(2'd2, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset MANUAL: got 0x%08h required 0", rd); end
    cfg_rd(2'd3, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset STATUS: got 0x%08h required 0", rd); end
    checks++; if (avm_chipselect !== 1'b0) begin errors++; $display("FAIL reset avm_chipselect: got %b required 0", avm_chipselect); end
    checks++; if (avm_write_n !== 1'b1) begin errors++; $display("FAIL reset avm_write_n: got %b required 1", avm_write_n); end
    checks++; if (avm_writedata !== 32'd0 || avm_address !== 2'd0) begin
      errors++; $display("FAIL reset avm data/addr: got 0x%08h/%0d required 0/0", avm_writedata, avm_address);
    end
  endtask

  task automatic test_chase(input int p);
    logic [31:0] exp;
    clear_log();
    cfg_wr(2'd1, 32'(p));
    cfg_wr(2'd0, 32'h1);
    wait_beats(12, 12 * (p + 2) + 20, "chase");
    for (int k = 0; k < 12 && k < beat_dat.size(); k++) begin
      exp = 32'd1 << (k % 10);
      checks++;
      if (beat_dat[k] !== exp) begin errors++; $display("FAIL chase beat%0d: got 0x%03h required 0x%03h", k, beat_dat[k], exp); end
      if (k > 0) begin
        checks++;
        if (beat_cyc[k] - beat_cyc[k-1] !== p + 2) begin
          errors++; $display("FAIL chase gap%0d: got %0d required %0d", k, beat_cyc[k] - beat_cyc[k-1], p + 2);
        end
      end
    end
    stop_seq();
  endtask

  task automatic test_bounce();
    int p, eff, m, pos;
    logic [31:0] exp;
    p   = $urandom_range(0, 2);
    eff = (p == 0) ? 1 : p;
    clear_log();
    cfg_wr(2'd1, 32'(p));
    cfg_wr(2'd0, 32'h3);
    wait_beats(22, 22 * (eff + 2) + 20, "bounce");
    for (int k = 0; k < 22 && k < beat_dat.size(); k++) begin
      m   = k % 18;
      pos = (m < 10) ? m : 18 - m;
      exp = 32'd1 << pos;
      checks++;
      if (beat_dat[k] !== exp) begin errors++; $display("FAIL bounce beat%0d: got 0x%03h required 0x%03h", k, beat_dat[k], exp); end
      if (k > 0) begin
        checks++;
        if (beat_cyc[k] - beat_cyc[k-1] !== eff + 2) begin
          errors++; $display("FAIL bounce gap%0d: got %0d required %0d", k, beat_cyc[k] - beat_cyc[k-1], eff + 2);
        end
      end
    end
    stop_seq();
  endtask

  task automatic test_blink_stall();
    int p, n_strb, n_bad;
    p = $urandom_range(1, 4);
    clear_log();
    stall_idx  = 1;
    stall_left = 4;
    cfg_wr(2'd1, 32'(p));
    cfg_wr(2'd0, 32'h5);
    wait_beats(3, 3 * (p + 2) + 40, "blink");
    if (beat_dat.size() >= 3) begin
      checks++; if (beat_dat[0] !== 32'h3FF) begin errors++; $display("FAIL blink beat0: got 0x%03h required 0x3ff", beat_dat[0]); end
      checks++; if (beat_dat[1] !== 32'h000) begin errors++; $display("FAIL blink beat1: got 0x%03h required 0x000", beat_dat[1]); end
      checks++; if (beat_dat[2] !== 32'h3FF) begin errors++; $display("FAIL blink beat2: got 0x%03h required 0x3ff", beat_dat[2]); end
      checks++;
      if (beat_cyc[1] - beat_cyc[0] !== p + 6) begin
        errors++; $display("FAIL blink stalled gap: got %0d required %0d", beat_cyc[1] - beat_cyc[0], p + 6);
      end
      checks++;
      if (beat_cyc[2] - beat_cyc[1] !== p + 2) begin
        errors++; $display("FAIL blink gap2: got %0d required %0d", beat_cyc[2] - beat_cyc[1], p + 2);
      end
    end
    n_strb = 0;
    n_bad  = 0;
    for (int i = 0; i < strb_idx.size(); i++) begin
      if (strb_idx[i] == 1) begin
        n_strb++;
        if (strb_dat[i] !== 32'h000) n_bad++;
      end
    end
    checks++; if (n_strb !== 5) begin errors++; $display("FAIL blink stall strobe cycles: got %0d required 5", n_strb); end
    checks++; if (n_bad !== 0) begin errors++; $display("FAIL blink stall data stable: got %0d unstable cycles required 0", n_bad); end
    stop_seq();
  endtask

  task automatic test_manual();
    logic [31:0] m0, m1;
    m0 = 32'h2A5;
    m1 = 32'($urandom_range(0, 1023));
    while (m1 == m0) m1 = 32'($urandom_range(0, 1023));
    clear_log();
    cfg_wr(2'd2, m0);
    cfg_wr(2'd1, 32'd0);
    cfg_wr(2'd0, 32'h7);
    wait_beats(3, 40, "manual");
    // The beat just landed, so this write falls inside the WAIT phase.
    cfg_wr(2'd2, m1);
    wait_beats(5, 40, "manual2");
    for (int k = 0; k < 5 && k < beat_dat.size(); k++) begin
      checks++;
      if (beat_dat[k] !== ((k < 3) ? m0 : m1)) begin
        errors++; $display("FAIL manual beat%0d: got 0x%03h required 0x%03h", k, beat_dat[k], (k < 3) ? m0 : m1);
      end
      if (k > 0) begin
        checks++;
        if (beat_cyc[k] - beat_cyc[k-1] !== 3) begin
          errors++; $display("FAIL manual gap%0d: got %0d required 3", k, beat_cyc[k] - beat_cyc[k-1]);
        end
      end
    end
    stop_seq();
  endtask

  task automatic test_disable_stall();
    logic [31:0] rd;
    int t = 0;
    clear_log();
    stall_idx  = 1;
    stall_left = 6;
    cfg_wr(2'd1, 32'd2);
    cfg_wr(2'd0, 32'h1);
    while (stall_left == 6 && t < 60) begin
      tick();
      t++;
    end
    checks++;
    if (stall_left == 6) begin errors++; $display("FAIL disable stall start: got no stall required stall"); end
    cfg_wr(2'd0, 32'h0);
    repeat (40) tick();
    checks++; if (beat_dat.size() !== 2) begin errors++; $display("FAIL disable beat count: got %0d required 2", beat_dat.size()); end
    if (beat_dat.size() >= 2) begin
      checks++; if (beat_dat[1] !== 32'h002) begin errors++; $display("FAIL disable last beat: got 0x%03h required 0x002", beat_dat[1]); end
    end
    cfg_rd(2'd3, rd);
    checks++; if (rd[31] !== 1'b0) begin errors++; $display("FAIL disable busy: got %b required 0", rd[31]); end
    checks++; if (avm_chipselect !== 1'b0) begin errors++; $display("FAIL disable chipselect: got %b required 0", avm_chipselect); end
    stop_seq();
  endtask

  initial begin
    test_reset();
    test_chase(3);
    test_chase($urandom_range(1, 5));
    test_bounce();
    test_blink_stall();
    test_manual();
    test_disable_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
